iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
- Multi-cycle signed integer divider that supplies the quotient to the ALU's divide selection (s=2'b11); it also produces the remainder and a divide-by-zero flag.
- Uses a start/busy/done handshake, so the control sequencer stalls on busy instead of relying on a fixed clock-enable window.
- Restoring shift-subtract datapath, one quotient bit per clock, on operand magnitudes, followed by a sign-fixup cycle.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
dataa  input  WIDTH  signed dividend, sampled with start
datab  input  WIDTH  signed divisor, sampled with start
busy  output  1  high while a division is in progress (state != IDLE)
done  output  1  one-cycle registered pulse; results valid from this cycle
quotient  output  WIDTH  signed quotient, registered
remainder  output  WIDTH  signed remainder, registered
divzero  output  1  set with done when the divisor was zero

Behaviour:
- Reset is asynchronous and active-high. While reset is high: state=IDLE, busy=0, done=0, quotient=0, remainder=0, divzero=0, iteration counter=0. Reset mid-division aborts it and no done is produced.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at an edge:
  - latch the signs of dataa and datab;
  - latch |dataa| and |datab| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1));
  - clear the partial remainder; load the counter with WIDTH-1.
  - If datab==0, go to FIX; otherwise go to RUN.
- RUN, each edge:
  - shift {partial remainder, dividend} left by one;
  - trial-subtract the divisor magnitude from the partial remainder, using WIDTH+1-bit arithmetic;
  - if the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
  - Counter decrements. The edge at which the counter is 0 moves the state to FIX, so RUN lasts exactly WIDTH edges.
- FIX, one edge: register the outputs, set done=1, go to IDLE.
  - Quotient is negated when the operand signs differ. Remainder is negated when the dividend was negative (truncating division; remainder takes the dividend's sign).
  - Divide by zero: quotient = all ones, remainder = original dataa, divzero=1.
  - Otherwise divzero=0.
  - Results are taken modulo 2^WIDTH. Consequently -2^(WIDTH-1) / -1 yields quotient -2^(WIDTH-1), remainder 0, divzero=0.
- done is high for exactly one cycle, the cycle after the FIX edge, and is cleared at the next edge.
- busy is low in that done cycle.
- Latency, counting the edge that samples start as edge 1:
  - normal division: done is visible after edge WIDTH+2 (18 for WIDTH=16);
  - divide by zero: done is visible after edge 2.
- start while busy=1 is ignored; the operands are not resampled.
- start in the done cycle is accepted, giving back-to-back operation with no idle bubble.
- quotient, remainder and divzero hold their values from one done until the next FIX edge; they do not change during RUN.
- dataa and datab may change freely after the start edge.

Test Plan:
- Reset, then start with dataa=100, datab=7 -> done after edge 18: quotient=14, remainder=2, divzero=0; busy high from edge 1 through edge 18; done high for exactly one cycle.
- Sign matrix with ±100 and ±7: -100/7 -> q=-14 (0xFFF2), r=-2 (0xFFFE); 100/-7 -> q=-14, r=2; -100/-7 -> q=14, r=-2.
- Boundary cases:
  - -32768/-1 -> q=0x8000, r=0.
  - -32768/1 -> q=0x8000, r=0.
  - 32767/32767 -> q=1, r=0.
  - 3/5 -> q=0, r=3.
- Divide by zero, 5/0 -> done after edge 2: quotient=0xFFFF, remainder=5, divzero=1. A following 9/3 -> q=3, divzero=0.
- Handshake:
  - pulse start again at edge 5 of a running 100/7 with dataa=1, datab=1 -> ignored; result is still 14 r 2.
  - assert start with 20/6 in the done cycle -> accepted; 18 edges later q=3, r=2.
- Reset asserted asynchronously mid-RUN (between edges) -> busy, done and outputs go to 0 immediately with no done pulse; a fresh 100/7 then completes normally.

Source files
------------

// File: rtl/iter_divider.sv
// Multi-cycle signed restoring divider with start/busy/done handshake.
// One quotient bit per clock on magnitudes, then a sign-fixup cycle.
module iter_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_n;

  logic             sa, sb;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic             neg;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? -v : v;
  endfunction

  assign busy = (state != IDLE);

  // Shifted partial remainder and trial difference, one bit wider.
  assign sh   = {prem, dvd[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};
  assign neg  = diff[WIDTH];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = (datab == '0) ? FIX : RUN;
      RUN:  if (cnt == '0) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sa        <= 1'b0;
      sb        <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      prem      <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divzero   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sa   <= dataa[WIDTH-1];
            sb   <= datab[WIDTH-1];
            dvd  <= mag(dataa);
            dvs  <= mag(datab);
            prem <= '0;
            cnt  <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          prem <= neg ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
          dvd  <= {dvd[WIDTH-2:0], ~neg};
          cnt  <= cnt - CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          // Zero divisor skips RUN, so dvd still holds |dataa|.
          if (dvs == '0) begin
            quotient  <= '1;
            remainder <= sa ? -dvd : dvd;
            divzero   <= 1'b1;
          end else begin
            quotient  <= (sa ^ sb) ? -dvd : dvd;
            remainder <= sa ? -prem : prem;
            divzero   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: model results queued at start,
// compared when done pulses; latency, handshake and reset checked inline.
module tb_iter_divider;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] dataa;
  logic [15:0] datab;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        divzero;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_chk  = 0;
  logic [15:0] held_q = '0;

  iter_divider #(.WIDTH(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .dataa    (dataa),
    .datab    (datab),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .divzero  (divzero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void push(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ib == 0) begin
      e.q  = 16'hFFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = 16'(ia / ib);
      e.r  = 16'(ia % ib);
      e.dz = 1'b0;
    end
    exp_q.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("divzero", 32'(divzero), 32'(e.dz));
        held_q = e.q;
      end
    end
  end

  // Drives one division; inj>0 pulses a stray start (1/1) at that edge.
  // Returns #1 after the edge that raised done, i.e. inside the done cycle.
  task automatic go(input logic [15:0] a, input logic [15:0] b,
                    input int inj);
    int n;
    int lat;
    lat = (b == 16'd0) ? 2 : 18;
    @(negedge clock);
    start = 1'b1;
    dataa = a;
    datab = b;
    push(a, b);
    n = 0;
    do begin
      @(posedge clock);
      n++;
      #1;
      if (n == 1) begin
        start = 1'b0;
        dataa = 16'($urandom);
        datab = 16'($urandom);
        chk("busy_start", 32'(busy), 32'd1);
      end
      if (n == 5 && lat == 18) chk("hold_q", 32'(quotient), 32'(held_q));
      if (inj != 0 && n == inj - 1) begin
        start = 1'b1;
        dataa = 16'd1;
        datab = 16'd1;
      end
      if (inj != 0 && n == inj) start = 1'b0;
    end while (!done && n < 40);
    chk("latency", 32'(n), 32'(lat));
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic gap();
    @(posedge clock);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dataa = '0;
    datab = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(divzero), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    go(16'd100, 16'd7, 0);      gap();
    go(16'(-100), 16'd7, 0);    gap();
    go(16'd100, 16'(-7), 0);    gap();
    go(16'(-100), 16'(-7), 0);  gap();
    go(16'h8000, 16'hFFFF, 0);  gap();
    go(16'h8000, 16'd1, 0);     gap();
    go(16'd32767, 16'd32767, 0); gap();
    go(16'd3, 16'd5, 0);        gap();
    go(16'd5, 16'd0, 0);        gap();
    go(16'h8000, 16'd0, 0);     gap();
    go(16'd9, 16'd3, 0);        gap();
    go(16'd100, 16'd7, 5);      gap();

    // Back-to-back: second start lands in the first one's done cycle.
    go(16'd100, 16'd7, 0);
    go(16'd20, 16'd6, 0);       gap();

    for (int i = 0; i < 6; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom_range(0, 3) == 0 ? $urandom_range(1, 9) : $urandom);
      go(a, b, 0);
      gap();
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clock);
    start = 1'b1;
    dataa = 16'd100;
    datab = 16'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_q", 32'(quotient), 32'd0);
    chk("arst_r", 32'(remainder), 32'd0);
    chk("arst_dz", 32'(divzero), 32'd0);
    held_q = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    chk("arst_idle", 32'(busy), 32'd0);

    go(16'd100, 16'd7, 0);      gap();

    repeat (2) @(posedge clock);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
